// File: rtl/hazard_unit.sv
// hazard_unit: pipeline interlock for a 5-stage core.
// Tracks the instructions sitting in EXE and MEM, stalls the ID stage on
// data hazards and while a multi-cycle MULT occupies EXE, and flushes IF/ID
// on a taken branch. Keeps a saturating count of stall cycles.
// Build option: define FORWARDING_EN when the datapath forwards results, so
// that only load-use pairs need to stall.
module hazard_unit #(
    parameter int REG_ADDR_LEN = 5,
    parameter int MULT_LAT     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [REG_ADDR_LEN-1:0] src1,
    input  logic [REG_ADDR_LEN-1:0] src2,
    input  logic                    two_src,
    input  logic                    id_wb_en,
    input  logic                    id_mem_r_en,
    input  logic                    id_is_mult,
    input  logic [REG_ADDR_LEN-1:0] id_dest,
    input  logic                    branch_taken,
    output logic                    hazard_detected,
    output logic                    flush,
    output logic [15:0]             stall_cnt
);

    // Cycles a MULT still holds EXE after the cycle it enters it.
    localparam logic [3:0] MULT_RELOAD = 4'(MULT_LAT - 1);

    typedef struct packed {
        logic                    valid;
        logic                    wb_en;
        logic                    mem_r_en;
        logic [REG_ADDR_LEN-1:0] dest;
    } slot_t;

    slot_t       exe_reg, exe_next;
    slot_t       mem_reg, mem_next;
    slot_t       id_slot;
    logic [3:0]  mult_cnt_reg, mult_cnt_next;
    logic [15:0] stall_cnt_reg, stall_cnt_next;

    logic                         mult_busy;
    logic                         data_hazard;
    logic                         issue;
    logic [1:0][REG_ADDR_LEN-1:0] src_addr;
    logic [1:0]                   src_used;
    logic [1:0]                   exe_hit;
    logic                         slot_bits_unused;

    assign id_slot   = {1'b1, id_wb_en, id_mem_r_en, id_dest};
    assign src_addr  = {src2, src1};
    assign src_used  = {two_src, 1'b1};
    assign mult_busy = (mult_cnt_reg != 4'd0);

    // Per-source match against the EXE slot; register 0 is hardwired and never matches.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_exe_hit
            assign exe_hit[gi] = src_used[gi] && (src_addr[gi] != '0) &&
                                 exe_reg.valid && exe_reg.wb_en &&
                                 (exe_reg.dest == src_addr[gi]);
        end
    endgenerate

`ifdef FORWARDING_EN
    // Results are forwarded, so only a load still in EXE forces a stall.
    assign data_hazard      = (|exe_hit) && exe_reg.mem_r_en;
    assign slot_bits_unused = ^mem_reg;
`else
    logic [1:0] mem_hit;

    // Per-source match against the MEM slot (no forwarding: MEM results also block).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_mem_hit
            assign mem_hit[gi] = src_used[gi] && (src_addr[gi] != '0) &&
                                 mem_reg.valid && mem_reg.wb_en &&
                                 (mem_reg.dest == src_addr[gi]);
        end
    endgenerate

    assign data_hazard      = (|exe_hit) || (|mem_hit);
    assign slot_bits_unused = ^{mem_reg.mem_r_en, exe_reg.mem_r_en};
`endif

    // A taken branch discards the ID instruction, so it can never be the one stalling.
    assign hazard_detected = !rst && !branch_taken &&
                             ((id_valid && data_hazard) || mult_busy);
    assign flush     = branch_taken;
    assign issue     = id_valid && !hazard_detected && !flush;
    assign stall_cnt = stall_cnt_reg;

    // Next-state: slot advance, MULT occupancy countdown and stall counter.
    always_comb begin
        exe_next       = exe_reg;
        mem_next       = mem_reg;
        mult_cnt_next  = mult_cnt_reg;
        stall_cnt_next = stall_cnt_reg;

        if (mult_busy) begin
            // MULT keeps EXE; MEM sees bubbles until it drains.
            mult_cnt_next = mult_cnt_reg - 4'd1;
            mem_next      = '0;
        end else begin
            mem_next = exe_reg;
            if (issue) begin
                exe_next = id_slot;
                if (id_is_mult) begin
                    mult_cnt_next = MULT_RELOAD;
                end
            end else begin
                exe_next = '0;
            end
        end

        if (hazard_detected && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_next = stall_cnt_reg + 16'd1;
        end
    end

    // State registers; reset clears everything, aborting any MULT in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            exe_reg       <= '0;
            mem_reg       <= '0;
            mult_cnt_reg  <= 4'd0;
            stall_cnt_reg <= 16'd0;
        end else begin
            exe_reg       <= exe_next;
            mem_reg       <= mem_next;
            mult_cnt_reg  <= mult_cnt_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

endmodule
